cpu_mul_pipe: RTL and testbench

Pipelined integer multiplier feeding the register bank's dedicated multiply write-back port (write_enable_mul / write_reg_mul / write_data_mul). It accepts one multiply per cycle from issue, carries destination tags through a fixed-depth pipeline, and retires the low half of the product straight into the register file. It also reports whether either decode source register has an in-flight multiply, so issue can stall on RAW hazards.

---
 rtl/cpu_mul_pkg.sv | 24 ++
 rtl/cpu_mul_pipe_if.sv | 35 +++
 rtl/cpu_mul_stage.sv | 34 +++
 rtl/cpu_mul_pipe.sv | 87 ++++++++
 tb/tb_cpu_mul_pipe.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mul_pkg.sv
// rtl/cpu_mul_pkg.sv - shared widths, stage record and stage-count bounds for the multiply pipe
package cpu_mul_pkg;

  localparam int REG_WIDTH          = 32;
  localparam int REG_ADDR_WIDTH     = 5;
  localparam int MUL_STAGES_DEFAULT = 4;
  localparam int MUL_STAGES_MIN     = 2;
  localparam int MUL_STAGES_MAX     = 8;

  // One pipeline slot: invalid slots always carry zero dest/data so the
  // last stage can drive the write-back port without extra gating.
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic [REG_WIDTH-1:0]      data;
  } mul_stage_t;

  function automatic bit mul_stages_ok(input int n);
    return (n >= MUL_STAGES_MIN) && (n <= MUL_STAGES_MAX);
  endfunction

  localparam bit MUL_STAGES_OK = mul_stages_ok(MUL_STAGES_DEFAULT);

endpackage

// File: rtl/cpu_mul_pipe_if.sv
// rtl/cpu_mul_pipe_if.sv - issue, hazard-query and write-back signals of the multiply pipe
interface cpu_mul_pipe_if;
  import cpu_mul_pkg::*;

  logic                      issue_valid;
  logic                      issue_ready;
  logic [REG_WIDTH-1:0]      issue_src_a;
  logic [REG_WIDTH-1:0]      issue_src_b;
  logic [REG_ADDR_WIDTH-1:0] issue_dest;
  logic                      flush;
  logic [REG_ADDR_WIDTH-1:0] query_reg_a;
  logic [REG_ADDR_WIDTH-1:0] query_reg_b;
  logic                      pending_a;
  logic                      pending_b;
  logic                      write_enable_mul;
  logic [REG_ADDR_WIDTH-1:0] write_reg_mul;
  logic [REG_WIDTH-1:0]      write_data_mul;

  // Issue/decode side
  modport master (
    output issue_valid, issue_src_a, issue_src_b, issue_dest, flush,
           query_reg_a, query_reg_b,
    input  issue_ready, pending_a, pending_b,
           write_enable_mul, write_reg_mul, write_data_mul
  );

  // Multiply pipe side
  modport slave (
    input  issue_valid, issue_src_a, issue_src_b, issue_dest, flush,
           query_reg_a, query_reg_b,
    output issue_ready, pending_a, pending_b,
           write_enable_mul, write_reg_mul, write_data_mul
  );

endinterface

// File: rtl/cpu_mul_stage.sv
// rtl/cpu_mul_stage.sv - one multiply pipeline register with synchronous clear
module cpu_mul_stage
  import cpu_mul_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  mul_stage_t stage_in,
  output mul_stage_t stage_out
);

  mul_stage_t stage_d;
  mul_stage_t stage_q;

  // Pass the upstream slot through unless the pipe is being flushed
  always_comb begin
    stage_d = stage_in;
    if (clear) begin
      stage_d = '0;
    end
  end

  // Slot register; reset empties it
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_out = stage_q;

endmodule

// File: rtl/cpu_mul_pipe.sv
// rtl/cpu_mul_pipe.sv - pipelined multiplier retiring into the bank multiply port (flush: CPU_MUL_FLUSH_EN)
module cpu_mul_pipe
  import cpu_mul_pkg::*;
#(
  parameter int MUL_STAGES = MUL_STAGES_DEFAULT
)
(
  input logic           clock,
  input logic           reset,
  cpu_mul_pipe_if.slave bus
);

  if (!mul_stages_ok(MUL_STAGES)) begin : g_stage_check
    $error("cpu_mul_pipe: MUL_STAGES must be within 2..8");
  end

  logic       accept;
  logic       flush_en;
  logic       pending_a;
  logic       pending_b;
  mul_stage_t issue_stage;
  mul_stage_t stage_q [MUL_STAGES];

  // The bank port never stalls, so the only time requests are refused is reset
  assign bus.issue_ready = !reset;
  assign accept          = bus.issue_valid && !reset;

`ifdef CPU_MUL_FLUSH_EN
  assign flush_en = bus.flush;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_en     = 1'b0;
`endif

  // Form the low half of the product at entry; later stages only carry it,
  // leaving synthesis free to retime the multiplier across them
  always_comb begin
    issue_stage = '0;
    if (accept) begin
      issue_stage.valid = 1'b1;
      issue_stage.dest  = bus.issue_dest;
      issue_stage.data  = bus.issue_src_a * bus.issue_src_b;
    end
  end

  for (genvar i = 0; i < MUL_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      cpu_mul_stage u_stage (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush_en),
        .stage_in  (issue_stage),
        .stage_out (stage_q[i])
      );
    end else begin : g_next
      cpu_mul_stage u_stage (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush_en),
        .stage_in  (stage_q[i-1]),
        .stage_out (stage_q[i])
      );
    end
  end

  // RAW hazard lookup across every in-flight slot, including the one retiring now
  always_comb begin
    pending_a = 1'b0;
    pending_b = 1'b0;
    for (int i = 0; i < MUL_STAGES; i++) begin
      if (stage_q[i].valid && (stage_q[i].dest == bus.query_reg_a)) begin
        pending_a = 1'b1;
      end
      if (stage_q[i].valid && (stage_q[i].dest == bus.query_reg_b)) begin
        pending_b = 1'b1;
      end
    end
  end

  assign bus.pending_a        = pending_a;
  assign bus.pending_b        = pending_b;
  assign bus.write_enable_mul = stage_q[MUL_STAGES-1].valid;
  assign bus.write_reg_mul    = stage_q[MUL_STAGES-1].dest;
  assign bus.write_data_mul   = stage_q[MUL_STAGES-1].data;

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// tb/tb_cpu_mul_pipe.sv - self-checking bench for cpu_mul_pipe (honours CPU_MUL_FLUSH_EN)
module tb_cpu_mul_pipe;
  import cpu_mul_pkg::*;

  localparam int S = 4;
`ifdef CPU_MUL_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  cpu_mul_pipe_if bus ();

  cpu_mul_pipe #(.MUL_STAGES(S)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called just after a falling edge; the request is accepted at the next rising edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                       input logic [31:0] r, input bit push);
    bus.issue_valid = 1'b1;
    bus.issue_src_a = a;
    bus.issue_src_b = b;
    bus.issue_dest  = d;
    if (push) sb.push_back('{d, r, cyc + S});
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_src_a = '0;
    bus.issue_src_b = '0;
    bus.issue_dest  = '0;
  endtask

  // Drop expectations that have not reached the write-back port yet
  task automatic trim();
    while (sb.size() > 0 && sb[$].cyc > cyc) sb.delete(sb.size() - 1);
  endtask

  // Write-back monitor: every strobe must match the oldest expectation, on time
  always @(negedge clock) begin
    exp_t e;
    if (mon_on) begin
      if (bus.write_enable_mul === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb", bus.write_enable_mul, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("wb_reg", bus.write_reg_mul, e.dest);
          chk("wb_data", bus.write_data_mul, e.data);
          chk("wb_latency", cyc, e.cyc);
        end
      end else begin
        chk("idle_wb_en", bus.write_enable_mul, 1'b0);
        chk("idle_wb_reg", bus.write_reg_mul, 0);
        chk("idle_wb_data", bus.write_data_mul, 0);
      end
    end
  end

  vec_t vt[8];

  initial begin
    vt[0] = '{32'd3,         32'd5,         5'd4,  32'd15};
    vt[1] = '{32'hFFFF_FFFF, 32'd2,         5'd1,  32'hFFFF_FFFE};
    vt[2] = '{32'h8000_0000, 32'h8000_0000, 5'd2,  32'h0000_0000};
    vt[3] = '{32'd2,         32'd2,         5'd9,  32'd4};
    vt[4] = '{32'd3,         32'd3,         5'd9,  32'd9};
    vt[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'd1};
    vt[6] = '{32'h1234_5678, 32'h10,        5'd31, 32'h2345_6780};
    vt[7] = '{32'hDEAD_BEEF, 32'd0,         5'd3,  32'd0};

    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.query_reg_a = '0;
    bus.query_reg_b = '0;
    idle();

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_wb_en", bus.write_enable_mul, 1'b0);
    chk("rst_wb_reg", bus.write_reg_mul, 0);
    chk("rst_wb_data", bus.write_data_mul, 0);
    chk("rst_pending_a", bus.pending_a, 1'b0);
    chk("rst_pending_b", bus.pending_b, 1'b0);
    chk("rst_ready", bus.issue_ready, 1'b0);
    mon_on = 1'b1;
    reset  = 1'b0;
    #1 chk("ready", bus.issue_ready, 1'b1);

    // Back-to-back table vectors, one per cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      issue(vt[i].a, vt[i].b, vt[i].d, vt[i].r, 1'b1);
    end
    @(negedge clock);
    idle();
    repeat (S + 2) @(negedge clock);
    chk("table_drained", sb.size(), 0);

    // Hazard window for a single op to r7
    @(negedge clock);
    bus.query_reg_a = 5'd7;
    bus.query_reg_b = 5'd6;
    issue(32'd6, 32'd7, 5'd7, 32'd42, 1'b1);
    for (int i = 1; i <= S + 1; i++) begin
      @(negedge clock);
      idle();
      #1;
      chk($sformatf("pending_a_%0d", i), bus.pending_a, (i <= S) ? 1'b1 : 1'b0);
      chk($sformatf("pending_b_%0d", i), bus.pending_b, 1'b0);
    end
    repeat (2) @(negedge clock);

    // Flush with three ops in flight plus one presented at the flush edge
    bus.query_reg_a = 5'd10;
    bus.query_reg_b = 5'd11;
    @(negedge clock); issue(32'd7,   32'd6, 5'd14, 32'd42,  1'b1);
    @(negedge clock); issue(32'd9,   32'd9, 5'd10, 32'd81,  1'b1);
    @(negedge clock); issue(32'd100, 32'd3, 5'd11, 32'd300, 1'b1);
    @(negedge clock); idle();
    @(negedge clock);
    bus.flush = 1'b1;
    if (FLUSH_EN) trim();
    issue(32'd5, 32'd5, 5'd10, 32'd25, !FLUSH_EN);
    @(negedge clock);
    bus.flush = 1'b0;
    idle();
    #1;
    chk("flush_pending_a", bus.pending_a, !FLUSH_EN);
    chk("flush_pending_b", bus.pending_b, !FLUSH_EN);
    repeat (S + 2) @(negedge clock);
    chk("flush_drained", sb.size(), 0);

    // Reset two cycles after an issue discards it; requests during reset are dropped
    bus.query_reg_a = 5'd12;
    bus.query_reg_b = 5'd13;
    @(negedge clock); issue(32'd4, 32'd4, 5'd12, 32'd16, 1'b1);
    @(negedge clock); idle();
    @(negedge clock);
    reset = 1'b1;
    trim();
    issue(32'd2, 32'd2, 5'd13, 32'd4, 1'b0);
    @(negedge clock);
    #1;
    chk("midrst_wb_en", bus.write_enable_mul, 1'b0);
    chk("midrst_wb_reg", bus.write_reg_mul, 0);
    chk("midrst_wb_data", bus.write_data_mul, 0);
    chk("midrst_pending_a", bus.pending_a, 1'b0);
    chk("midrst_pending_b", bus.pending_b, 1'b0);
    chk("midrst_ready", bus.issue_ready, 1'b0);
    reset = 1'b0;
    idle();

    // Bounded final drain, then watch for stray strobes
    begin
      int n;
      n = 0;
      while (sb.size() > 0 && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    chk("final_drained", sb.size(), 0);
    repeat (S + 2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
